cvxif_offload_ctrl: RTL
=======================

# cvxif_offload_ctrl

Sequencer between the issue stage and the CoreV-X-Interface coprocessor port. It gates offload issue against an outstanding-instruction budget and sends the commit for every accepted instruction. It turns rejected offloads into illegal-instruction exceptions and tracks in-flight transaction IDs. Coprocessor results are registered onto a single backpressured writeback port, and a pipeline flush kills all in-flight offloads.

## Interface
- TRANS_ID_BITS, 3, width of transaction IDs; ID space holds 2^TRANS_ID_BITS entries
- MAX_OUTSTANDING, 4, max accepted-but-unretired offloads (1..2^TRANS_ID_BITS)
- XLEN, 64, register/result width
- Reset is rst_ni, asynchronous, active-low; clock is clk_i.
- clk_i in 1: clock
- rst_ni in 1: async active-low reset
- flush_i in 1: kill all in-flight offloads
- off_valid_i / off_ready_o in/out 1: issue-stage handshake
- off_instr_i in 32: offloaded instruction
- off_id_i in TRANS_ID_BITS: issue-stage transaction ID
- off_rs1_i, off_rs2_i in XLEN: source operands
- cp_issue_valid_o / cp_issue_ready_i out/in 1: coprocessor issue handshake
- cp_issue_instr_o out 32, cp_issue_id_o out TRANS_ID_BITS, cp_issue_rs1_o / cp_issue_rs2_o out XLEN: issue payload
- cp_issue_accept_i in 1: coprocessor accepts the instruction (sampled at handshake)
- cp_issue_writeback_i in 1: accepted instruction will return a result
- cp_commit_valid_o out 1, cp_commit_id_o out TRANS_ID_BITS, cp_commit_kill_o out 1: commit pulse
- cp_result_valid_i / cp_result_ready_o in/out 1: result handshake
- cp_result_id_i in TRANS_ID_BITS, cp_result_data_i in XLEN, cp_result_we_i in 1, cp_result_exc_i in 1, cp_result_exccode_i in 6: result payload
- wb_valid_o / wb_ready_i out/in 1: writeback handshake
- wb_id_o out TRANS_ID_BITS, wb_result_o out XLEN, wb_we_o out 1: writeback payload
- wb_exc_valid_o out 1, wb_exc_cause_o out XLEN, wb_exc_tval_o out XLEN: exception fields
- outstanding_o out $clog2(MAX_OUTSTANDING+1): in-flight count
- spurious_o out 1: one-cycle pulse when a result with an untracked ID is dropped

## Operation
- State: busy bit per ID, count, commit register (pend, id), illegal register (pend, id, instr), one-entry output register.
- Issue is combinational. The gate `ok` is !flush_i && !illegal_pend && count<MAX_OUTSTANDING && !busy[off_id_i].
- cp_issue_valid_o = off_valid_i && ok. off_ready_o = cp_issue_ready_i && ok. The payload is passed through unchanged.
- A handshake (fire) is cp_issue_valid_o && cp_issue_ready_i.
- Fire with accept=1:
  - Commit register loads (pend=1, id).
  - If writeback=1: busy[id] is set and count increments.
  - If writeback=0: nothing is tracked.
- Fire with accept=0: the illegal register loads (pend=1, id, instr). No commit is sent for a rejected instruction.
- Commit: cp_commit_valid_o = commit pend, for exactly one cycle. cp_commit_kill_o = flush_i in that cycle.
- Output register sources, in priority order:
  - (1) Illegal pending: wb_exc_valid_o=1, wb_exc_cause_o=2 (ILLEGAL_INSTR), wb_exc_tval_o=zero-extended instr, wb_result_o=0, wb_we_o=0. Clears illegal pend.
  - (2) Coprocessor result handshake.
- Loading: the output register loads when empty or draining (wb_valid_o && wb_ready_i).
- cp_result_ready_o = (empty || draining) && !illegal_pend.
- Result with busy[id]=1:
  - Output register loads data, we, exc, and cause = zero-extended exccode; tval=0.
  - busy[id] clears and count decrements.
- Result with busy[id]=0: it is consumed, not forwarded, and spurious_o pulses.
- Same-cycle increment and decrement leave count unchanged.
- flush_i clears all busy bits, count, illegal pend and wb_valid_o. Results arriving afterwards are dropped as spurious.

## Timing
- Reset values: every register cleared; all outputs 0 (cp_issue_valid_o / off_ready_o follow inputs combinationally).
- Issue: 0-cycle combinational pass-through.
- Commit: 1 cycle after the accepting fire.
- Illegal exception: wb_valid_o asserts 1 cycle after the rejecting fire, when the output register is free.
- Result to writeback: 1 cycle. wb_* stay stable while wb_valid_o && !wb_ready_i.
- Throughput: one issue and one result per cycle sustained with wb_ready_i=1.
- Reset mid-operation: all state cleared immediately (async).

## Test plan
- **Accept + result:** issue id=2, accept=1, wb=1; result id=2 data=0xDEAD 2 cycles later.
  - Commit id=2 kill=0 at +1; outstanding_o=1.
  - wb_valid_o with id=2 result=0xDEAD one cycle after the result; then outstanding_o=0.
- **Reject:** issue id=5 instr=0x0000_700B, accept=0.
  - No commit; off_ready_o=0 while pending.
  - Next cycle wb: id=5, exc_valid=1, cause=2, tval=0x700B.
- **Budget full:** 4 accepted id=0..3 with no results. off_ready_o=0 for id=4; returning result id=1 re-enables issue.
- **Duplicate ID:** busy[3]=1 and an issue with id=3 stalls until result id=3 retires.
- **Flush:** flush_i in the commit cycle after an accept of id=1.
  - cp_commit_kill_o=1; outstanding_o=0.
  - A later result id=1 gives spurious_o=1 and no wb.
- **Backpressure:** wb_ready_i=0 for 3 cycles with 2 results pending. The first is held stable, cp_result_ready_o=0, and the results drain in order after release.

Source files
------------

// File: rtl/cvxif_offload_ctrl_if.sv
// Bundle of the issue-stage, coprocessor and writeback signals of cvxif_offload_ctrl.
// The master modport is the controller's view; the slave modport is its environment.
interface cvxif_offload_ctrl_if #(
  parameter int unsigned TRANS_ID_BITS   = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned XLEN            = 64
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                     flush_i;
  logic                     off_valid_i;
  logic                     off_ready_o;
  logic [31:0]              off_instr_i;
  logic [TRANS_ID_BITS-1:0] off_id_i;
  logic [XLEN-1:0]          off_rs1_i;
  logic [XLEN-1:0]          off_rs2_i;

  logic                     cp_issue_valid_o;
  logic                     cp_issue_ready_i;
  logic [31:0]              cp_issue_instr_o;
  logic [TRANS_ID_BITS-1:0] cp_issue_id_o;
  logic [XLEN-1:0]          cp_issue_rs1_o;
  logic [XLEN-1:0]          cp_issue_rs2_o;
  logic                     cp_issue_accept_i;
  logic                     cp_issue_writeback_i;

  logic                     cp_commit_valid_o;
  logic [TRANS_ID_BITS-1:0] cp_commit_id_o;
  logic                     cp_commit_kill_o;

  logic                     cp_result_valid_i;
  logic                     cp_result_ready_o;
  logic [TRANS_ID_BITS-1:0] cp_result_id_i;
  logic [XLEN-1:0]          cp_result_data_i;
  logic                     cp_result_we_i;
  logic                     cp_result_exc_i;
  logic [5:0]               cp_result_exccode_i;

  logic                     wb_valid_o;
  logic                     wb_ready_i;
  logic [TRANS_ID_BITS-1:0] wb_id_o;
  logic [XLEN-1:0]          wb_result_o;
  logic                     wb_we_o;
  logic                     wb_exc_valid_o;
  logic [XLEN-1:0]          wb_exc_cause_o;
  logic [XLEN-1:0]          wb_exc_tval_o;

  logic [CNT_W-1:0]         outstanding_o;
  logic                     spurious_o;

  modport master (
    input  flush_i, off_valid_i, off_instr_i, off_id_i, off_rs1_i, off_rs2_i,
    input  cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i,
    input  cp_result_valid_i, cp_result_id_i, cp_result_data_i, cp_result_we_i,
    input  cp_result_exc_i, cp_result_exccode_i, wb_ready_i,
    output off_ready_o, cp_issue_valid_o, cp_issue_instr_o, cp_issue_id_o,
    output cp_issue_rs1_o, cp_issue_rs2_o,
    output cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o, cp_result_ready_o,
    output wb_valid_o, wb_id_o, wb_result_o, wb_we_o,
    output wb_exc_valid_o, wb_exc_cause_o, wb_exc_tval_o, outstanding_o, spurious_o
  );

  modport slave (
    output flush_i, off_valid_i, off_instr_i, off_id_i, off_rs1_i, off_rs2_i,
    output cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i,
    output cp_result_valid_i, cp_result_id_i, cp_result_data_i, cp_result_we_i,
    output cp_result_exc_i, cp_result_exccode_i, wb_ready_i,
    input  off_ready_o, cp_issue_valid_o, cp_issue_instr_o, cp_issue_id_o,
    input  cp_issue_rs1_o, cp_issue_rs2_o,
    input  cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o, cp_result_ready_o,
    input  wb_valid_o, wb_id_o, wb_result_o, wb_we_o,
    input  wb_exc_valid_o, wb_exc_cause_o, wb_exc_tval_o, outstanding_o, spurious_o
  );
endinterface

// File: rtl/cvxif_offload_ctrl.sv
// Offload sequencer between issue stage and CV-X-IF coprocessor: budgeted issue, commit,
// illegal-instruction conversion, in-flight ID tracking and a one-entry writeback register.
module cvxif_offload_ctrl #(
  parameter int unsigned TRANS_ID_BITS   = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned XLEN            = 64
) (
  input logic                clk_i,
  input logic                rst_ni,
  cvxif_offload_ctrl_if.master bus
);
  localparam int unsigned NUM_IDS = 1 << TRANS_ID_BITS;
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);

  typedef logic [TRANS_ID_BITS-1:0] id_t;

  function automatic logic [XLEN-1:0] zext_instr(input logic [31:0] instr);
    return XLEN'(instr);
  endfunction

  function automatic logic [XLEN-1:0] zext_code(input logic [5:0] code);
    return XLEN'(code);
  endfunction

  logic [NUM_IDS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               commit_pend_q;
  id_t                commit_id_q;
  logic               ill_pend_q;
  id_t                ill_id_q;
  logic [31:0]        ill_instr_q;
  logic               spurious_q;

  logic               vld_p1;
  id_t                wb_id_p1;
  logic [XLEN-1:0]    wb_result_p1;
  logic               wb_we_p1;
  logic               wb_exc_p1;
  logic [XLEN-1:0]    wb_cause_p1;
  logic [XLEN-1:0]    wb_tval_p1;

  logic ok, fire, acc_fire, rej_fire, track;
  logic draining, out_free, ill_src, res_ready, res_fire, res_hit;
  id_t         ill_id_src;
  logic [31:0] ill_instr_src;

  // Issue gate: stage 0 is purely combinational
  assign ok = !bus.flush_i && !ill_pend_q && (count_q < CNT_W'(MAX_OUTSTANDING))
              && !busy_q[bus.off_id_i];
  assign bus.cp_issue_valid_o = bus.off_valid_i && ok;
  assign bus.off_ready_o      = bus.cp_issue_ready_i && ok;
  assign bus.cp_issue_instr_o = bus.off_instr_i;
  assign bus.cp_issue_id_o    = bus.off_id_i;
  assign bus.cp_issue_rs1_o   = bus.off_rs1_i;
  assign bus.cp_issue_rs2_o   = bus.off_rs2_i;

  assign fire     = bus.cp_issue_valid_o && bus.cp_issue_ready_i;
  assign acc_fire = fire && bus.cp_issue_accept_i;
  assign rej_fire = fire && !bus.cp_issue_accept_i;
  assign track    = acc_fire && bus.cp_issue_writeback_i;

  // A rejection goes straight to writeback when the register is free; the illegal
  // register only holds it while the output is blocked, so latency stays one cycle.
  assign draining      = vld_p1 && bus.wb_ready_i;
  assign out_free      = !vld_p1 || draining;
  assign ill_src       = ill_pend_q || rej_fire;
  assign ill_id_src    = ill_pend_q ? ill_id_q : bus.off_id_i;
  assign ill_instr_src = ill_pend_q ? ill_instr_q : bus.off_instr_i;
  assign res_ready     = out_free && !ill_src;
  assign res_fire      = bus.cp_result_valid_i && res_ready;
  assign res_hit       = res_fire && busy_q[bus.cp_result_id_i];

  assign bus.cp_result_ready_o = res_ready;

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (track)   busy_d[bus.off_id_i]     = 1'b1;
    if (res_hit) busy_d[bus.cp_result_id_i] = 1'b0;
    case ({track, res_hit})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (bus.flush_i) begin
      busy_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q        <= '0;
      count_q       <= '0;
      commit_pend_q <= 1'b0;
      commit_id_q   <= '0;
      ill_pend_q    <= 1'b0;
      ill_id_q      <= '0;
      ill_instr_q   <= '0;
      spurious_q    <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      count_q       <= count_d;
      commit_pend_q <= acc_fire;
      if (acc_fire) commit_id_q <= bus.off_id_i;
      spurious_q    <= res_fire && !busy_q[bus.cp_result_id_i];
      if (bus.flush_i) begin
        ill_pend_q <= 1'b0;
      end else if (rej_fire && !out_free) begin
        ill_pend_q  <= 1'b1;
        ill_id_q    <= bus.off_id_i;
        ill_instr_q <= bus.off_instr_i;
      end else if (out_free) begin
        ill_pend_q <= 1'b0;
      end
    end
  end

  // Stage 1: writeback register, holds while wb_valid_o && !wb_ready_i
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1       <= 1'b0;
      wb_id_p1     <= '0;
      wb_result_p1 <= '0;
      wb_we_p1     <= 1'b0;
      wb_exc_p1    <= 1'b0;
      wb_cause_p1  <= '0;
      wb_tval_p1   <= '0;
    end else if (bus.flush_i) begin
      vld_p1 <= 1'b0;
    end else if (out_free) begin
      if (ill_src) begin
        vld_p1       <= 1'b1;
        wb_id_p1     <= ill_id_src;
        wb_result_p1 <= '0;
        wb_we_p1     <= 1'b0;
        wb_exc_p1    <= 1'b1;
        wb_cause_p1  <= CAUSE_ILLEGAL;
        wb_tval_p1   <= zext_instr(ill_instr_src);
      end else if (res_hit) begin
        vld_p1       <= 1'b1;
        wb_id_p1     <= bus.cp_result_id_i;
        wb_result_p1 <= bus.cp_result_data_i;
        wb_we_p1     <= bus.cp_result_we_i;
        wb_exc_p1    <= bus.cp_result_exc_i;
        wb_cause_p1  <= zext_code(bus.cp_result_exccode_i);
        wb_tval_p1   <= '0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.cp_commit_valid_o = commit_pend_q;
  assign bus.cp_commit_id_o    = commit_id_q;
  assign bus.cp_commit_kill_o  = commit_pend_q && bus.flush_i;
  assign bus.wb_valid_o        = vld_p1;
  assign bus.wb_id_o           = wb_id_p1;
  assign bus.wb_result_o       = wb_result_p1;
  assign bus.wb_we_o           = wb_we_p1;
  assign bus.wb_exc_valid_o    = wb_exc_p1;
  assign bus.wb_exc_cause_o    = wb_cause_p1;
  assign bus.wb_exc_tval_o     = wb_tval_p1;
  assign bus.outstanding_o     = count_q;
  assign bus.spurious_o        = spurious_q;
endmodule
